// File: rtl/rf_pkg.sv
// Shared register-file types, default sizes and the byte-merge helper.
// Imported by decode, writeback and the register file itself.
package rf_pkg;

    localparam int RF_XLEN  = 32;
    localparam int RF_NREGS = 32;
    localparam int RF_AW    = $clog2(RF_NREGS);

    // Widest word the merge helper handles; callers zero-extend into it.
    localparam int RF_MAX_W = 256;
    localparam int RF_MAX_B = RF_MAX_W / 8;

    typedef struct packed {
        logic             en;
        logic [RF_AW-1:0] addr;
    } rf_rd_req_t;

    typedef struct packed {
        logic               en;
        logic [RF_AW-1:0]   addr;
        logic [RF_XLEN/8-1:0] be;
        logic [RF_XLEN-1:0] data;
    } rf_wr_req_t;

    function automatic logic [RF_MAX_W-1:0] rf_merge_bytes(
        input logic [RF_MAX_W-1:0] old_w,
        input logic [RF_MAX_W-1:0] new_w,
        input logic [RF_MAX_B-1:0] be
    );
        logic [RF_MAX_W-1:0] res;
        res = old_w;
        for (int b = 0; b < RF_MAX_B; b++) begin
            if (be[b]) begin
                res[b*8 +: 8] = new_w[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: issue reserves, writeback clears, flush wipes.
// Reserve beats a same-cycle clear; flush beats everything.
module rf_scoreboard import rf_pkg::*; #(
    parameter int DEPTH    = RF_NREGS,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int N_RD     = 2,
    parameter int N_WR     = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rsv_en,
    input  logic [ADDR_W-1:0]      rsv_addr,
    input  logic                   flush,
    input  logic [N_WR-1:0]        wr_en,
    input  logic [N_WR*ADDR_W-1:0] wr_addr,
    input  logic [N_RD*ADDR_W-1:0] rd_addr,
    output logic [N_RD-1:0]        rd_busy
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Next busy state: clears first, then reserve, then flush on top.
    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < N_WR; w++) begin
            if (wr_en[w]) begin
                busy_d[wr_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (rsv_en) begin
            busy_d[rsv_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    // Busy bit storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Raw busy lookup for each read port.
    always_comb begin
        rd_busy = '0;
        for (int r = 0; r < N_RD; r++) begin
            rd_busy[r] = busy_q[rd_addr[r*ADDR_W +: ADDR_W]];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with byte-enabled writes,
// optional write bypass, optional registered reads and a busy scoreboard.
module regfile_mp import rf_pkg::*; #(
    parameter int DATA_W   = RF_XLEN,
    parameter int DEPTH    = RF_NREGS,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int N_RD     = 2,
    parameter int N_WR     = 1,
    parameter int ZERO_REG = 1,
    parameter int RD_REG   = 0,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_RD-1:0]          rd_en,
    input  logic [N_RD*ADDR_W-1:0]   rd_addr,
    output logic [N_RD*DATA_W-1:0]   rd_data,
    output logic [N_RD-1:0]          rd_busy,
    input  logic [N_WR-1:0]          wr_en,
    input  logic [N_WR*ADDR_W-1:0]   wr_addr,
    input  logic [N_WR*DATA_W/8-1:0] wr_be,
    input  logic [N_WR*DATA_W-1:0]   wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic                     flush
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0]      regs_q [DEPTH];
    logic [DATA_W-1:0]      regs_d [DEPTH];
    logic [N_RD-1:0]        sb_busy;
    logic [N_RD*DATA_W-1:0] rd_data_d;
    logic [N_RD-1:0]        rd_busy_d;

    function automatic logic [DATA_W-1:0] mrg(
        input logic [DATA_W-1:0] o,
        input logic [DATA_W-1:0] n,
        input logic [NB-1:0]     be
    );
        logic [RF_MAX_W-1:0] ow;
        logic [RF_MAX_W-1:0] nw;
        logic [RF_MAX_W-1:0] rw;
        logic [RF_MAX_B-1:0] bw;
        ow = '0;
        nw = '0;
        bw = '0;
        ow[DATA_W-1:0] = o;
        nw[DATA_W-1:0] = n;
        bw[NB-1:0]     = be;
        rw = rf_merge_bytes(ow, nw, bw);
        return rw[DATA_W-1:0];
    endfunction

    rf_scoreboard #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .N_RD     (N_RD),
        .N_WR     (N_WR),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .flush    (flush),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rd_addr  (rd_addr),
        .rd_busy  (sb_busy)
    );

    // Merge all write ports in index order so higher ports win per byte.
    // regs_d doubles as the bypassed "current value" of every register.
    always_comb begin
        logic [ADDR_W-1:0] wa;
        wa = '0;
        regs_d = regs_q;
        for (int w = 0; w < N_WR; w++) begin
            wa = wr_addr[w*ADDR_W +: ADDR_W];
            if (wr_en[w] && !(ZERO_REG != 0 && wa == '0)) begin
                regs_d[wa] = mrg(regs_d[wa],
                                 wr_data[w*DATA_W +: DATA_W],
                                 wr_be[w*NB +: NB]);
            end
        end
    end

    // Register storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Per-port read value and busy, gated by rd_en.
    // Bypass is suppressed under reset so outputs follow the cleared state.
    always_comb begin
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] val;
        logic              hit;
        logic              rsv_hit;
        logic              bsy;
        ra        = '0;
        val       = '0;
        hit       = 1'b0;
        rsv_hit   = 1'b0;
        bsy       = 1'b0;
        rd_data_d = '0;
        rd_busy_d = '0;
        for (int r = 0; r < N_RD; r++) begin
            ra  = rd_addr[r*ADDR_W +: ADDR_W];
            hit = 1'b0;
            for (int w = 0; w < N_WR; w++) begin
                if (wr_en[w] && wr_addr[w*ADDR_W +: ADDR_W] == ra) begin
                    hit = 1'b1;
                end
            end
            rsv_hit = rsv_en && (rsv_addr == ra);
            if (RD_REG != 0) begin
                val = regs_d[ra];
            end else if (BYPASS != 0 && !rst) begin
                val = regs_d[ra];
            end else begin
                val = regs_q[ra];
            end
            if (ZERO_REG != 0 && ra == '0) begin
                val = '0;
            end
            bsy = sb_busy[r];
            if (BYPASS != 0 && hit && !rsv_hit) begin
                bsy = 1'b0;
            end
            if (rd_en[r]) begin
                rd_data_d[r*DATA_W +: DATA_W] = val;
                rd_busy_d[r]                  = bsy;
            end
        end
    end

    generate
        if (RD_REG != 0) begin : g_rd_reg
            logic [N_RD*DATA_W-1:0] rd_data_q;
            logic [N_RD-1:0]        rd_busy_q;

            // Registered read outputs, one-cycle latency.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data_q <= '0;
                    rd_busy_q <= '0;
                end else begin
                    rd_data_q <= rd_data_d;
                    rd_busy_q <= rd_busy_d;
                end
            end

            assign rd_data = rd_data_q;
            assign rd_busy = rd_busy_q;
        end else begin : g_rd_comb
            assign rd_data = rd_data_d;
            assign rd_busy = rd_busy_d;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: three configurations share one stimulus
// (bypass comb read, no-bypass comb read, registered read).
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [7:0]  wr_be;
    logic [63:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        flush;

    logic [63:0] rd_data_a, rd_data_b, rd_data_c;
    logic [1:0]  rd_busy_a, rd_busy_b, rd_busy_c;

    int checks = 0;
    int errors = 0;

    regfile_mp #(.N_WR(2), .BYPASS(1), .RD_REG(0)) dut_a (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_a), .rd_busy(rd_busy_a), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush)
    );

    regfile_mp #(.N_WR(2), .BYPASS(0), .RD_REG(0)) dut_b (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_b), .rd_busy(rd_busy_b), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush)
    );

    regfile_mp #(.N_WR(2), .BYPASS(1), .RD_REG(1)) dut_c (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_c), .rd_busy(rd_busy_c), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        rsv;
        logic [4:0]  rsa;
        logic        fl;
        logic [4:0]  ra;
        logic [31:0] ed;
        logic        eb;
    } vec_t;

    vec_t tv [12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        wr_en   = 2'b00;
        wr_addr = '0;
        wr_be   = '0;
        wr_data = '0;
        rsv_en  = 1'b0;
        rsv_addr = '0;
        flush   = 1'b0;
    endtask

    initial begin
        tv[0]  = '{1'b1, 5'd5, 4'hF, 32'h11223344, 1'b0, 5'd0, 1'b0, 5'd5, 32'h11223344, 1'b0};
        tv[1]  = '{1'b1, 5'd5, 4'h5, 32'hAABBCCDD, 1'b0, 5'd0, 1'b0, 5'd5, 32'h11BB33DD, 1'b0};
        tv[2]  = '{1'b1, 5'd0, 4'hF, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0, 32'h00000000, 1'b0};
        tv[3]  = '{1'b0, 5'd0, 4'h0, 32'h0,        1'b1, 5'd9, 1'b0, 5'd9, 32'h00000000, 1'b1};
        tv[4]  = '{1'b1, 5'd9, 4'hF, 32'h99,       1'b0, 5'd0, 1'b0, 5'd9, 32'h00000099, 1'b0};
        tv[5]  = '{1'b1, 5'd9, 4'hF, 32'h77,       1'b1, 5'd9, 1'b0, 5'd9, 32'h00000077, 1'b1};
        tv[6]  = '{1'b0, 5'd0, 4'h0, 32'h0,        1'b1, 5'd4, 1'b1, 5'd4, 32'h00000000, 1'b0};
        tv[7]  = '{1'b0, 5'd0, 4'h0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd9, 32'h00000077, 1'b0};
        tv[8]  = '{1'b0, 5'd0, 4'h0, 32'h0,        1'b1, 5'd6, 1'b0, 5'd6, 32'h00000000, 1'b1};
        tv[9]  = '{1'b1, 5'd6, 4'h0, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b0, 5'd6, 32'h00000000, 1'b0};
        tv[10] = '{1'b0, 5'd0, 4'h0, 32'h0,        1'b1, 5'd0, 1'b0, 5'd0, 32'h00000000, 1'b0};
        tv[11] = '{1'b1, 5'd2, 4'hF, 32'hCAFE,     1'b0, 5'd0, 1'b0, 5'd2, 32'h0000CAFE, 1'b0};

        rst = 1'b1;
        rd_en = 2'b11;
        rd_addr = {5'd3, 5'd5};
        idle();
        #3;
        chk("reset_rd_data", rd_data_a[31:0], 32'h0);
        chk("reset_rd_busy", {30'd0, rd_busy_a}, 32'h0);
        #9;
        rst = 1'b0;

        // Table: apply op for one edge, then read back combinationally.
        for (int i = 0; i < 12; i++) begin
            idle();
            wr_en[0]      = tv[i].we;
            wr_addr[4:0]  = tv[i].wa;
            wr_be[3:0]    = tv[i].be;
            wr_data[31:0] = tv[i].wd;
            rsv_en        = tv[i].rsv;
            rsv_addr      = tv[i].rsa;
            flush         = tv[i].fl;
            @(posedge clk);
            #1;
            idle();
            rd_en   = 2'b01;
            rd_addr = {5'd0, tv[i].ra};
            #1;
            chk($sformatf("vec%0d_data", i), rd_data_a[31:0], tv[i].ed);
            chk($sformatf("vec%0d_busy", i), {31'd0, rd_busy_a[0]},
                {31'd0, tv[i].eb});
            chk($sformatf("vec%0d_data_nobyp", i), rd_data_b[31:0], tv[i].ed);
        end

        // Disabled read port returns 0.
        rd_en = 2'b01;
        rd_addr = {5'd5, 5'd5};
        #1;
        chk("rd_en0_data", rd_data_a[63:32], 32'h0);
        chk("rd_en1_data", rd_data_a[31:0], 32'h11BB33DD);

        // Same-cycle write and read of r7.
        idle();
        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd7};
        wr_be = 8'h0F;
        wr_data = {32'h0, 32'h55};
        rd_en = 2'b01;
        rd_addr = {5'd0, 5'd7};
        #1;
        chk("bypass_on", rd_data_a[31:0], 32'h55);
        chk("bypass_off_old", rd_data_b[31:0], 32'h0);
        @(posedge clk);
        #1;
        idle();
        #1;
        chk("bypass_off_next", rd_data_b[31:0], 32'h55);

        // Busy masking by a same-cycle write.
        rsv_en = 1'b1;
        rsv_addr = 5'd8;
        @(posedge clk);
        #1;
        idle();
        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd8};
        wr_be = 8'h0F;
        wr_data = {32'h0, 32'h8};
        rd_addr = {5'd0, 5'd8};
        #1;
        chk("busy_mask_byp", {31'd0, rd_busy_a[0]}, 32'h0);
        chk("busy_nomask", {31'd0, rd_busy_b[0]}, 32'h1);

        // Two ports hitting r3.
        @(posedge clk);
        #1;
        idle();
        wr_en = 2'b11;
        wr_addr = {5'd3, 5'd3};
        wr_be = 8'hFF;
        wr_data = {32'h2, 32'h1};
        @(posedge clk);
        #1;
        idle();
        rd_addr = {5'd0, 5'd3};
        #1;
        chk("multi_full", rd_data_a[31:0], 32'h2);
        wr_en = 2'b11;
        wr_addr = {5'd3, 5'd3};
        wr_be = 8'h1F;
        wr_data = {32'hFF, 32'h12345600};
        @(posedge clk);
        #1;
        idle();
        #1;
        chk("multi_byte", rd_data_a[31:0], 32'h123456FF);

        // Registered read of r2 on dut_c.
        rd_en = 2'b01;
        rd_addr = {5'd0, 5'd2};
        @(posedge clk);
        #1;
        chk("rdreg_n1", rd_data_c[31:0], 32'h0000CAFE);
        rd_en = 2'b00;
        @(posedge clk);
        #1;
        chk("rdreg_n2_off", rd_data_c[31:0], 32'h0);

        // Registered read captures a same-cycle write.
        rd_en = 2'b01;
        rd_addr = {5'd0, 5'd10};
        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd10};
        wr_be = 8'h0F;
        wr_data = {32'h0, 32'hABCD};
        @(posedge clk);
        #1;
        idle();
        chk("rdreg_wr_capture", rd_data_c[31:0], 32'h0000ABCD);

        // Mid-cycle async reset with traffic in flight.
        rd_en = 2'b11;
        rd_addr = {5'd12, 5'd5};
        rsv_en = 1'b1;
        rsv_addr = 5'd12;
        @(posedge clk);
        #1;
        idle();
        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd5};
        wr_be = 8'h0F;
        wr_data = {32'h0, 32'hFFFFFFFF};
        #1;
        chk("pre_rst_busy", {31'd0, rd_busy_a[1]}, 32'h1);
        chk("pre_rst_byp", rd_data_a[31:0], 32'hFFFFFFFF);
        chk("pre_rst_rdreg", rd_data_c[31:0], 32'h11BB33DD);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_data_a", rd_data_a[31:0], 32'h0);
        chk("rst_busy_a", {30'd0, rd_busy_a}, 32'h0);
        chk("rst_data_b", rd_data_b[31:0], 32'h0);
        chk("rst_data_c", rd_data_c[31:0], 32'h0);
        idle();
        #1;
        rst = 1'b0;
        #1;
        chk("post_rst_r5", rd_data_a[31:0], 32'h0);
        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd5};
        wr_be = 8'h0F;
        wr_data = {32'h0, 32'h1234};
        @(posedge clk);
        #1;
        idle();
        #1;
        chk("post_rst_write", rd_data_b[31:0], 32'h1234);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
